rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/dst_addr/dst) between two writeback sources: ALU result and memory load result.
- Each source has a 1-entry holding register. A round-robin arbiter drains the holding registers to the register-file port, one write per cycle.
- Exports pending-write (scoreboard) flags for two read addresses so decode can stall on RAW hazards.
- Sits between the pipeline writeback stage and the register file.

---
 rtl/rf_wb_pkg.sv | 17 +
 rtl/rf_wb_arbiter_if.sv | 42 ++++
 rtl/rf_wb_slot.sv | 41 ++++
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, holding-entry struct and grant pointer type for the writeback arbiter
package rf_wb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              older;
  } hold_entry_t;

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } grant_ptr_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request, register-file write and scoreboard bundle; fwd ports under RF_WB_FWD_EN
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic              alu_vld;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_rdy;
  logic              mem_vld;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rdy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dst_addr;
  logic [DATA_W-1:0] rf_dst;
  logic [ADDR_W-1:0] rd0_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic              pend0;
  logic              pend1;
`ifdef RF_WB_FWD_EN
  logic              fwd0_vld;
  logic [DATA_W-1:0] fwd0_data;
  logic              fwd1_vld;
  logic [DATA_W-1:0] fwd1_data;
`endif

  modport master (
`ifdef RF_WB_FWD_EN
    input  fwd0_vld, fwd0_data, fwd1_vld, fwd1_data,
`endif
    output alu_vld, alu_addr, alu_data, mem_vld, mem_addr, mem_data, rd0_addr, rd1_addr,
    input  alu_rdy, mem_rdy, rf_we, rf_dst_addr, rf_dst, pend0, pend1
  );

  modport slave (
`ifdef RF_WB_FWD_EN
    output fwd0_vld, fwd0_data, fwd1_vld, fwd1_data,
`endif
    input  alu_vld, alu_addr, alu_data, mem_vld, mem_addr, mem_data, rd0_addr, rd1_addr,
    output alu_rdy, mem_rdy, rf_we, rf_dst_addr, rf_dst, pend0, pend1
  );
endinterface

// File: rtl/rf_wb_slot.sv
// rtl/rf_wb_slot.sv - one-entry writeback holding register with capture/drain, age bit and read-address compare
module rf_wb_slot
  import rf_wb_pkg::*;
#(
  parameter bit IS_MEM = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              drain,
  input  logic              other_cap,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rdy,
  output logic              cap,
  output logic              hit0,
  output logic              hit1,
  output hold_entry_t       entry
);
  assign rdy  = !entry.valid || drain;
  assign cap  = vld && rdy;
  assign hit0 = entry.valid && (entry.addr == rd0_addr);
  assign hit1 = entry.valid && (entry.addr == rd1_addr);

  // On a same-edge capture the load is the earlier instruction, so only the mem slot becomes older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (cap) begin
      entry.valid <= 1'b1;
      entry.addr  <= addr;
      entry.data  <= data;
      entry.older <= other_cap && IS_MEM;
    end else begin
      if (drain) entry.valid <= 1'b0;
      if (other_cap && entry.valid && !drain) entry.older <= 1'b1;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source register-file writeback arbiter with RAW scoreboard; RF_WB_FWD_EN adds forwarding
module rf_wb_arbiter
  import rf_wb_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  rf_wb_arbiter_if.slave bus
);
  hold_entry_t       alu_e, mem_e;
  logic              alu_cap, mem_cap;
  logic              alu_hit0, alu_hit1, mem_hit0, mem_hit1;
  logic              drain_alu, drain_mem, rr_issue, iss_vld;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;
  grant_ptr_t        ptr, ptr_next;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  rf_wb_slot #(.IS_MEM(1'b0)) u_alu_slot (
    .clk(clk), .rst_n(rst_n), .vld(bus.alu_vld), .addr(bus.alu_addr), .data(bus.alu_data),
    .drain(drain_alu), .other_cap(mem_cap), .rd0_addr(bus.rd0_addr), .rd1_addr(bus.rd1_addr),
    .rdy(bus.alu_rdy), .cap(alu_cap), .hit0(alu_hit0), .hit1(alu_hit1), .entry(alu_e)
  );

  rf_wb_slot #(.IS_MEM(1'b1)) u_mem_slot (
    .clk(clk), .rst_n(rst_n), .vld(bus.mem_vld), .addr(bus.mem_addr), .data(bus.mem_data),
    .drain(drain_mem), .other_cap(alu_cap), .rd0_addr(bus.rd0_addr), .rd1_addr(bus.rd1_addr),
    .rdy(bus.mem_rdy), .cap(mem_cap), .hit0(mem_hit0), .hit1(mem_hit1), .entry(mem_e)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= LAST_MEM;
    else        ptr <= ptr_next;
  end

  always_comb begin
    ptr_next = ptr;
    if (rr_issue) ptr_next = drain_mem ? LAST_MEM : LAST_ALU;
  end

  // Same-address conflicts follow age so the register ends with the younger value.
  always_comb begin
    drain_alu = 1'b0;
    drain_mem = 1'b0;
    rr_issue  = 1'b0;
    if (alu_e.valid && mem_e.valid) begin
      if (alu_e.addr == mem_e.addr) begin
        drain_mem = mem_e.older;
        drain_alu = !mem_e.older;
      end else begin
        rr_issue  = 1'b1;
        drain_mem = (ptr == LAST_ALU);
        drain_alu = (ptr == LAST_MEM);
      end
    end else begin
      drain_alu = alu_e.valid;
      drain_mem = mem_e.valid;
    end
  end

  assign iss_vld  = drain_alu || drain_mem;
  assign iss_addr = drain_mem ? mem_e.addr : alu_e.addr;
  assign iss_data = drain_mem ? mem_e.data : alu_e.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= iss_vld && (iss_addr != '0);
      if (iss_vld) begin
        rf_addr_q <= iss_addr;
        rf_data_q <= iss_data;
      end
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_dst_addr = rf_addr_q;
  assign bus.rf_dst      = rf_data_q;

  // The issuing write still counts until the register file has absorbed it.
  assign bus.pend0 = (bus.rd0_addr != '0) &&
                     (alu_hit0 || mem_hit0 || (rf_we_q && rf_addr_q == bus.rd0_addr));
  assign bus.pend1 = (bus.rd1_addr != '0) &&
                     (alu_hit1 || mem_hit1 || (rf_we_q && rf_addr_q == bus.rd1_addr));

`ifdef RF_WB_FWD_EN
  always_comb begin
    bus.fwd0_data = rf_data_q;
    if (alu_hit0 && mem_hit0)  bus.fwd0_data = alu_e.older ? mem_e.data : alu_e.data;
    else if (alu_hit0)         bus.fwd0_data = alu_e.data;
    else if (mem_hit0)         bus.fwd0_data = mem_e.data;
    bus.fwd1_data = rf_data_q;
    if (alu_hit1 && mem_hit1)  bus.fwd1_data = alu_e.older ? mem_e.data : alu_e.data;
    else if (alu_hit1)         bus.fwd1_data = alu_e.data;
    else if (mem_hit1)         bus.fwd1_data = mem_e.data;
  end
  assign bus.fwd0_vld = bus.pend0;
  assign bus.fwd1_vld = bus.pend1;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed bench for rf_wb_arbiter; checks forwarding when RF_WB_FWD_EN is defined
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [DATA_W-1:0] regfile [16];

  always #5 clk = ~clk;

  rf_wb_arbiter_if bus();
  rf_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic idle_inputs();
    bus.alu_vld = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_vld = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.rd0_addr = 4'd3; bus.rd1_addr = 4'd4;
    do_reset();
    #1;
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst} !== 21'h0) begin
      bad++; $display("FAIL reset_rf: got %h want 0", {bus.rf_we, bus.rf_dst_addr, bus.rf_dst});
    end
    total++;
    if ({bus.alu_rdy, bus.mem_rdy} !== 2'b11) begin
      bad++; $display("FAIL reset_rdy: got %b want 11", {bus.alu_rdy, bus.mem_rdy});
    end
    total++;
    if ({bus.pend0, bus.pend1} !== 2'b00) begin
      bad++; $display("FAIL reset_pend: got %b want 00", {bus.pend0, bus.pend1});
    end
  endtask

  task automatic test_single_alu();
    bus.rd0_addr = 4'd3;
    bus.alu_vld = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 16'h1234;
    @(negedge clk);
    idle_inputs();
    total++;
    if ({bus.pend0, bus.rf_we} !== 2'b10) begin
      bad++; $display("FAIL single_held: got pend0/we %b want 10", {bus.pend0, bus.rf_we});
    end
`ifdef RF_WB_FWD_EN
    total++;
    if ({bus.fwd0_vld, bus.fwd0_data} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL single_fwd: got %h want 11234", {bus.fwd0_vld, bus.fwd0_data});
    end
`endif
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.pend0} !== {1'b1, 4'd3, 16'h1234, 1'b1}) begin
      bad++; $display("FAIL single_issue: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.pend0}, {1'b1, 4'd3, 16'h1234, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.pend0} !== 2'b00) begin
      bad++; $display("FAIL single_done: got we/pend0 %b want 00", {bus.rf_we, bus.pend0});
    end
  endtask

  task automatic test_simul_diff();
    do_reset();
    bus.rd0_addr = 4'd5; bus.rd1_addr = 4'd6;
    bus.alu_vld = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 16'hAAAA;
    bus.mem_vld = 1'b1; bus.mem_addr = 4'd6; bus.mem_data = 16'hBBBB;
    @(negedge clk);
    idle_inputs();
    total++;
    if ({bus.alu_rdy, bus.mem_rdy, bus.pend0, bus.pend1} !== 4'b1011) begin
      bad++; $display("FAIL simul_held: got rdy/pend %b want 1011",
                      {bus.alu_rdy, bus.mem_rdy, bus.pend0, bus.pend1});
    end
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.mem_rdy} !== {1'b1, 4'd5, 16'hAAAA, 1'b1}) begin
      bad++; $display("FAIL simul_first: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.mem_rdy}, {1'b1, 4'd5, 16'hAAAA, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst} !== {1'b1, 4'd6, 16'hBBBB}) begin
      bad++; $display("FAIL simul_second: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst}, {1'b1, 4'd6, 16'hBBBB});
    end
    @(negedge clk);
    total++;
    if (bus.rf_we !== 1'b0) begin
      bad++; $display("FAIL simul_idle: got we %b want 0", bus.rf_we);
    end
  endtask

  task automatic test_same_addr();
    bus.rd0_addr = 4'd7;
    bus.alu_vld = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 16'h2222;
    bus.mem_vld = 1'b1; bus.mem_addr = 4'd7; bus.mem_data = 16'h1111;
    @(negedge clk);
    idle_inputs();
`ifdef RF_WB_FWD_EN
    total++;
    if ({bus.fwd0_vld, bus.fwd0_data} !== {1'b1, 16'h2222}) begin
      bad++; $display("FAIL same_fwd: got %h want 12222", {bus.fwd0_vld, bus.fwd0_data});
    end
`endif
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst} !== {1'b1, 4'd7, 16'h1111}) begin
      bad++; $display("FAIL same_first: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst}, {1'b1, 4'd7, 16'h1111});
    end
    if (bus.rf_we) regfile[bus.rf_dst_addr] = bus.rf_dst;
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst} !== {1'b1, 4'd7, 16'h2222}) begin
      bad++; $display("FAIL same_second: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst}, {1'b1, 4'd7, 16'h2222});
    end
    if (bus.rf_we) regfile[bus.rf_dst_addr] = bus.rf_dst;
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.pend0, regfile[7]} !== {2'b00, 16'h2222}) begin
      bad++; $display("FAIL same_final: got we/pend0/r7 %h want 02222", {bus.rf_we, bus.pend0, regfile[7]});
    end
  endtask

  task automatic test_streaming();
    int ai = 0, mi = 0, wi = 0;
    bit acc_a = 1'b0, acc_m = 1'b0, started = 1'b0;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    do_reset();
    for (int c = 0; c < 30 && wi < 8; c++) begin
      exp_addr = (wi % 2 == 0) ? 4'(1 + wi / 2) : 4'(9 + wi / 2);
      exp_data = (wi % 2 == 0) ? 16'(16'hA000 + wi / 2) : 16'(16'hB000 + wi / 2);
      if (bus.rf_we) begin
        started = 1'b1;
        total++;
        if ({bus.rf_dst_addr, bus.rf_dst} !== {exp_addr, exp_data}) begin
          bad++; $display("FAIL stream_order[%0d]: got %h want %h", wi,
                          {bus.rf_dst_addr, bus.rf_dst}, {exp_addr, exp_data});
        end
        wi++;
      end else if (started) begin
        total++; bad++;
        $display("FAIL stream_gap: got we 0 want 1 after %0d writes", wi);
      end
      if (acc_a) ai++;
      if (acc_m) mi++;
      bus.alu_vld = (ai < 4); bus.alu_addr = 4'(1 + ai); bus.alu_data = 16'(16'hA000 + ai);
      bus.mem_vld = (mi < 4); bus.mem_addr = 4'(9 + mi); bus.mem_data = 16'(16'hB000 + mi);
      if (c > 0 && ai < 4 && mi < 4) begin
        total++;
        if ((bus.alu_rdy ^ bus.mem_rdy) !== 1'b1) begin
          bad++; $display("FAIL stream_alt_rdy: got %b want one-hot", {bus.alu_rdy, bus.mem_rdy});
        end
      end
      acc_a = bus.alu_vld && bus.alu_rdy;
      acc_m = bus.mem_vld && bus.mem_rdy;
      @(negedge clk);
    end
    idle_inputs();
    total++;
    if (wi != 8) begin
      bad++; $display("FAIL stream_count: got %0d writes want 8", wi);
    end
  endtask

  task automatic test_addr_zero();
    bus.rd0_addr = 4'd0;
    bus.alu_vld = 1'b1; bus.alu_addr = 4'd0; bus.alu_data = 16'h5555;
    @(negedge clk);
    idle_inputs();
    total++;
    if ({bus.pend0, bus.alu_rdy} !== 2'b01) begin
      bad++; $display("FAIL zero_held: got pend0/rdy %b want 01", {bus.pend0, bus.alu_rdy});
    end
    @(negedge clk);
    total++;
    if ({bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.pend0} !== {1'b0, 4'd0, 16'h5555, 1'b0}) begin
      bad++; $display("FAIL zero_issue: got %h want %h",
                      {bus.rf_we, bus.rf_dst_addr, bus.rf_dst, bus.pend0}, {1'b0, 4'd0, 16'h5555, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    bus.rd0_addr = 4'd8; bus.rd1_addr = 4'd9;
    bus.alu_vld = 1'b1; bus.alu_addr = 4'd8; bus.alu_data = 16'h8888;
    bus.mem_vld = 1'b1; bus.mem_addr = 4'd9; bus.mem_data = 16'h9999;
    @(negedge clk);
    idle_inputs();
    total++;
    if ({bus.pend0, bus.pend1} !== 2'b11) begin
      bad++; $display("FAIL mid_held: got pend %b want 11", {bus.pend0, bus.pend1});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.alu_rdy, bus.mem_rdy, bus.pend0, bus.pend1, bus.rf_we} !== 5'b11000) begin
      bad++; $display("FAIL mid_reset: got rdy/pend/we %b want 11000",
                      {bus.alu_rdy, bus.mem_rdy, bus.pend0, bus.pend1, bus.rf_we});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({bus.rf_we, bus.pend0, bus.pend1} !== 3'b000) begin
        bad++; $display("FAIL mid_after[%0d]: got we/pend %b want 000", c, {bus.rf_we, bus.pend0, bus.pend1});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regfile[i] = '0;
    idle_inputs();
    bus.rd0_addr = '0; bus.rd1_addr = '0;
    test_reset();
    test_single_alu();
    test_simul_diff();
    test_same_addr();
    test_streaming();
    test_addr_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
